// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, wait-state tolerant imem handshake,
// stall/redirect handling and NOP bubbles. Optional FETCH_PERF_EN adds perf counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        validF
`ifdef FETCH_PERF_EN
  , output logic [31:0] perf_fetched
  , output logic [31:0] perf_bubbles
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] pc_inc;
  logic [31:0] target;

  assign pc_inc    = pc_q + 32'd4;
  assign target    = PCTargetE & 32'hFFFF_FFFC;
  assign imem_addr = pc_q;
  assign PCF       = pc_q;
  assign PCPlus4F  = pc_inc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    redir_d    = redir_q;
    imem_req   = 1'b0;
    instF      = NOP_INST;
    validF     = 1'b0;

    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (!PCSrcE && imem_ready) begin
          validF = 1'b1;
          instF  = imem_rdata;
        end
        if (PCSrcE) begin
          // An in-flight request cannot be withdrawn; park the target until it completes.
          if (imem_ready) begin
            pc_d = target;
          end else begin
            redir_d = target;
            state_d = DRAIN;
          end
        end else if (imem_ready) begin
          if (stallF) begin
            inst_buf_d = imem_rdata;
            state_d    = HOLD;
          end else begin
            pc_d = pc_inc;
          end
        end
      end

      HOLD: begin
        if (!PCSrcE) begin
          validF = 1'b1;
          instF  = inst_buf_q;
        end
        if (PCSrcE) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stallF) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end

      DRAIN: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          pc_d    = PCSrcE ? target : redir_q;
          state_d = FETCH;
        end else if (PCSrcE) begin
          redir_d = target;
        end
      end

      default: state_d = FETCH;
    endcase

    if (!rst) begin
      imem_req = 1'b0;
      instF    = NOP_INST;
      validF   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      inst_buf_q <= NOP_INST;
      redir_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
      redir_q    <= redir_d;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (validF && !stallF && !PCSrcE) perf_fetched <= perf_fetched + 32'd1;
      if (!validF)                      perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a transaction-level reference model
// checked every cycle on the falling clock edge.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        validF;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  fetch_stage #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .instF(instF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .validF(validF)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hABCD_0000;
  endfunction

  assign imem_rdata = memw(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: what is owed to the pipeline, tracked as flags rather than states.
  logic [31:0] m_pc, m_buf, m_redir;
  bit          m_hold, m_kill, m_known = 1'b0;

  always @(negedge clk) begin
    logic [31:0] tgt, ei;
    logic        ev;
    tgt = PCTargetE & 32'hFFFF_FFFC;
    if (!rst) begin
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, validF}, 32'd0);
      chk("rst_inst", instF, NOP);
      m_pc = RPC; m_buf = NOP; m_redir = '0;
      m_hold = 1'b0; m_kill = 1'b0; m_known = 1'b1;
    end else if (m_known) begin
      ev = !PCSrcE && (m_hold || (!m_kill && imem_ready));
      ei = !ev ? NOP : (m_hold ? m_buf : memw(m_pc));
      chk("m_req", {31'b0, imem_req}, {31'b0, !m_hold});
      if (!m_hold) chk("m_addr", imem_addr, m_pc);
      chk("m_valid", {31'b0, validF}, {31'b0, ev});
      chk("m_inst", instF, ei);
      chk("m_pcf", PCF, m_pc);
      chk("m_pc4", PCPlus4F, m_pc + 32'd4);
      if (m_hold) begin
        if (PCSrcE) begin m_pc = tgt; m_hold = 1'b0; end
        else if (!stallF) begin m_pc = m_pc + 32'd4; m_hold = 1'b0; end
      end else if (m_kill) begin
        if (imem_ready) begin m_pc = PCSrcE ? tgt : m_redir; m_kill = 1'b0; end
        else if (PCSrcE) m_redir = tgt;
      end else if (PCSrcE) begin
        if (imem_ready) m_pc = tgt;
        else begin m_kill = 1'b1; m_redir = tgt; end
      end else if (imem_ready) begin
        if (stallF) begin m_hold = 1'b1; m_buf = memw(m_pc); end
        else m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic drv(input logic r, input logic s, input logic p,
                     input logic [31:0] t, input logic rdy);
    rst = r; stallF = s; PCSrcE = p; PCTargetE = t; imem_ready = rdy;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 1);
    chk("reset_gate_req", {31'b0, imem_req}, 32'd0);
    chk("reset_gate_inst", instF, NOP);
    tick(); tick();

    // zero-wait fetch from RESET_PC
    drv(1, 0, 0, 0, 1);
    chk("first_addr", imem_addr, 32'h100);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_inst", instF, 32'hABCD_0100);
    chk("first_pc4", PCPlus4F, 32'h104);
    tick();

    // two wait states at 0x104
    drv(1, 0, 0, 0, 0);
    chk("wait1_valid", {31'b0, validF}, 32'd0);
    chk("wait1_inst", instF, NOP);
    tick();
    drv(1, 0, 0, 0, 0);
    chk("wait2_pcf", PCF, 32'h104);
    tick();
    drv(1, 0, 0, 0, 1);
    chk("wait_done_inst", instF, 32'hABCD_0104);
    tick();

    // stall for 3 cycles at 0x108
    drv(1, 1, 0, 0, 1);
    chk("stall_inst0", instF, 32'hABCD_0108);
    tick();
    drv(1, 1, 0, 0, 1);
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_inst", instF, 32'hABCD_0108);
    tick();
    drv(1, 1, 0, 0, 0);
    chk("hold_pcf", PCF, 32'h108);
    tick();
    drv(1, 0, 0, 0, 1);
    chk("hold_release_valid", {31'b0, validF}, 32'd1);
    tick();

    // redirect while 0x10C waits
    drv(1, 0, 1, 32'h200, 0);
    chk("kill_addr", imem_addr, 32'h10C);
    chk("kill_valid", {31'b0, validF}, 32'd0);
    tick();
    drv(1, 0, 0, 0, 0);
    chk("drain_addr", imem_addr, 32'h10C);
    tick();
    drv(1, 0, 0, 0, 1);
    chk("drain_done_valid", {31'b0, validF}, 32'd0);
    tick();
    drv(1, 0, 0, 0, 1);
    chk("target_addr", imem_addr, 32'h200);
    chk("target_inst", instF, 32'hABCD_0200);
    tick();

    // redirect beats stall in HOLD; low target bits dropped
    drv(1, 1, 0, 0, 1);
    tick();
    drv(1, 1, 1, 32'h303, 1);
    chk("hold_redir_valid", {31'b0, validF}, 32'd0);
    tick();
    drv(1, 0, 0, 0, 1);
    chk("hold_redir_addr", imem_addr, 32'h300);
    tick();

    // zero-wait redirect: single bubble
    drv(1, 0, 1, 32'h400, 1);
    tick();
    drv(1, 0, 0, 0, 1);
    chk("zw_redir_addr", imem_addr, 32'h400);
    tick();

    // repeated redirects while draining: newest target wins
    drv(1, 0, 1, 32'h500, 0); tick();
    drv(1, 0, 1, 32'h600, 0); tick();
    drv(1, 0, 0, 0, 0);        tick();
    drv(1, 0, 0, 0, 1);        tick();
    drv(1, 0, 0, 0, 1);
    chk("newest_target", imem_addr, 32'h600);
    tick();

    // redirect arriving on the draining request's ready cycle
    drv(1, 0, 1, 32'h700, 0);  tick();
    drv(1, 0, 1, 32'h800, 1);  tick();
    drv(1, 0, 0, 0, 1);
    chk("drain_ready_redir", imem_addr, 32'h800);
    tick();

    // PC wrap
    drv(1, 0, 1, 32'hFFFF_FFFC, 1); tick();
    drv(1, 0, 0, 0, 1);
    chk("wrap_pc4", PCPlus4F, 32'h0);
    tick();
    drv(1, 0, 0, 0, 1);
    chk("wrap_addr", imem_addr, 32'h0);
    tick();

    // reset abandons a waiting request
    drv(1, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0);
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    tick();
    drv(1, 0, 0, 0, 1);
    chk("post_rst_addr", imem_addr, 32'h100);
    tick();

`ifdef FETCH_PERF_EN
    drv(0, 0, 0, 0, 1); tick();
    for (int unsigned i = 0; i < 10; i++) begin
      drv(1, 0, 0, 0, 1); tick();
    end
    drv(1, 0, 1, 32'h900, 1); tick();
    drv(1, 0, 0, 0, 1);
    chk("perf_fetched", perf_fetched, 32'd10);
    chk("perf_bubbles", perf_bubbles, 32'd1);
    tick();
`endif

    drv(1, 0, 0, 0, 1);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I pipeline. Owns the PC register, issues requests to an instruction memory with variable wait states, and drives `instF`/`PCF`/`PCPlus4F` into the IF/ID pipeline register. Handles stall from the hazard unit and branch/jump redirects from Execute, including redirects that arrive while a memory request is in flight. When no valid instruction exists, it presents a NOP bubble.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `stallF`  in  1  hazard unit: hold the current fetch.
- `PCSrcE`  in  1  redirect request from Execute.
- `PCTargetE`  in  32  redirect target.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  word address of the request (byte address, bits [1:0] = 0).
- `imem_rdata`  in  32  instruction data; valid when `imem_req & imem_ready`.
- `imem_ready`  in  1  memory completes the current request this cycle.
- `instF`  out  32  instruction to IF/ID, or `NOP_INST`.
- `PCF`  out  32  PC of `instF`.
- `PCPlus4F`  out  32  `PCF + 4`, modulo 2^32.
- `validF`  out  1  `instF` is a real instruction.

## Operation
- Registers: `pc_q`, `inst_buf`, `redir_q`, and a 2-bit `state` in {FETCH, HOLD, DRAIN}.
- Memory protocol: once raised, `imem_req`/`imem_addr` stay stable until the cycle `imem_ready` = 1. `imem_ready` is ignored while `imem_req` = 0.
- FETCH: `imem_req` = 1 and `imem_addr` = `pc_q`.
  - `imem_ready` = 0: stay in FETCH; output NOP with `validF` = 0.
  - `imem_ready` = 1 and `stallF` = 0: `instF` = `imem_rdata`, `validF` = 1; `pc_q` <= `pc_q`+4.
  - `imem_ready` = 1 and `stallF` = 1: `instF` = `imem_rdata`, `validF` = 1; `inst_buf` <= `imem_rdata`; go to HOLD; `pc_q` is unchanged.
- HOLD: `imem_req` = 0; `instF` = `inst_buf`, `validF` = 1.
  - `stallF` = 0: `pc_q` <= `pc_q`+4; go to FETCH.
- DRAIN (killed request in flight): `imem_req` = 1, `imem_addr` = `pc_q`; output NOP with `validF` = 0.
  - On `imem_ready`: drop the data; `pc_q` <= `redir_q`; go to FETCH.
- Redirect (`PCSrcE` = 1) has priority over `stallF` in every state. The current output that cycle is forced to NOP with `validF` = 0.
  - FETCH with `imem_ready` = 1, or HOLD: `pc_q` <= `PCTargetE`; go to FETCH.
  - FETCH with `imem_ready` = 0: `redir_q` <= `PCTargetE`; go to DRAIN.
  - DRAIN with `imem_ready` = 0: `redir_q` <= `PCTargetE` (the newest target wins).
  - DRAIN with `imem_ready` = 1: `pc_q` <= `PCTargetE`; go to FETCH.
- `PCF` = `pc_q` and `PCPlus4F` = `pc_q`+4 in all states. The adder wraps at 2^32. `PCTargetE[1:0]` is forced to 0.

## Timing
- Reset (`rst` low at a rising edge): `pc_q` = `RESET_PC`, state = FETCH, `inst_buf` = `NOP_INST`, `redir_q` = 0.
  - While `rst` is low, outputs are gated: `imem_req` = 0, `instF` = `NOP_INST`, `validF` = 0.
  - After the reset edge, `PCF` = `RESET_PC` and `PCPlus4F` = `RESET_PC`+4.
- Reset mid-request: the request is abandoned. The memory must tolerate a dropped `imem_req`.
- First request: `imem_req` = 1 in the first cycle after `rst` rises.
- Zero-wait memory (`imem_ready` tied to 1): one instruction per cycle; combinational request-to-`instF` latency of 0 cycles.
- N wait states: N NOP cycles, then the instruction.
- Redirect with zero-wait memory: exactly one bubble; the target is requested the next cycle.
- Redirect during a wait: bubbles continue until the killed request completes, then one more cycle before the target request.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `perf_fetched` [31:0] and `perf_bubbles` [31:0].
  - Both reset to 0 and wrap at 2^32.
  - `perf_fetched` increments each cycle `validF` = 1 and `stallF` = 0 and `PCSrcE` = 0.
  - `perf_bubbles` increments each cycle `validF` = 0 while `rst` is high.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset with `RESET_PC` = 0x100 and zero-wait memory: after `rst` rises, `imem_addr` sequence is 0x100, 0x104, 0x108; `validF` = 1 every cycle.
- `imem_ready` low for 2 cycles at 0x104: two cycles of `instF` = 0x00000013 with `validF` = 0, then the data; `PCF` holds 0x104 throughout.
- `stallF` for 3 cycles while the instruction at 0x108 completes: `imem_req` = 0 in HOLD; `instF` stays that word; `PCF` = 0x108; advance to 0x10C after release.
- `PCSrcE` = 1 with `PCTargetE` = 0x200 while 0x10C is waiting:
  - `imem_addr` stays 0x10C until ready; that data is discarded.
  - Next request is to 0x200; no `validF` during the drain.
- `PCSrcE` and `stallF` both high in HOLD: redirect wins; next `imem_addr` = target.
- With `FETCH_PERF_EN`: 10 zero-wait fetches plus 1 redirect give `perf_fetched` = 10, `perf_bubbles` = 1.
